// File: rtl/keypad_if.sv
// keypad_if
// Bundles the keypad-facing signals of the scanner into one connection.
//   sync_col   4  synchronized keypad columns, active-low (0 = key closed)
//   rows       4  keypad row drive, one-hot active-low
//   key_code   4  index of last accepted key = {row_idx, col_idx}
//   key_valid  1  one-clock strobe in the cycle key_code updates
//   key_held   1  high while an accepted key remains pressed
// Modports:
//   master  the scanner side (drives rows and key outputs, reads columns)
//   slave   the keypad/consumer side (drives columns, reads the rest)
interface keypad_if;
  logic [3:0] sync_col;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  sync_col,
    output rows,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output sync_col,
    input  rows,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// 4x4 matrix keypad scan and debounce state machine. Drives one row low at a
// time, watches the synchronized active-low columns, debounces both press and
// release, and reports each accepted press as a one-clock key_valid strobe
// carrying the raw {row, col} key index.
// Parameters:
//   SCAN_DIV         clocks each row is driven before advancing (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable clocks needed to accept a press/release
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   kp     keypad_if.master: sync_col in; rows, key_code, key_valid, key_held out
module keypad_scanner #(
  parameter int SCAN_DIV        = 1200,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  keypad_if.master   kp
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t             state;
  logic [1:0]         row_idx;
  logic [1:0]         col_idx;
  logic [DWELL_W-1:0] dwell;
  logic [DEB_W-1:0]   deb;
  logic [3:0]         rows_q;
  logic [3:0]         key_code_q;
  logic               key_valid_q;
  logic               key_held_q;

  logic [1:0]         next_row;
  logic               watched_col;
  logic [1:0]         lowest_col;

  // Active-low one-hot row pattern for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // The next row to scan wraps naturally from 3 back to 0 in two bits. Only
  // the column that triggered the press is followed once a key is latched,
  // and the lowest-numbered closed column wins when several share a row.
  always_comb begin
    next_row    = row_idx + 2'd1;
    watched_col = kp.sync_col[col_idx];
    lowest_col  = 2'd0;
    if (!kp.sync_col[0])      lowest_col = 2'd0;
    else if (!kp.sync_col[1]) lowest_col = 2'd1;
    else if (!kp.sync_col[2]) lowest_col = 2'd2;
    else                      lowest_col = 2'd3;
  end

  // Single registered state machine. Every transition that leaves or
  // re-enters a state clears the counters, so neither counter ever needs to
  // saturate. The row drive register only moves together with row_idx, which
  // keeps rows frozen on the pressed row through DEBOUNCE/HELD/RELEASE.
  // key_valid defaults low every cycle so it can only ever be a single pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      dwell       <= '0;
      deb         <= '0;
      rows_q      <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            deb   <= '0;
            if (kp.sync_col == 4'b1111) begin
              row_idx <= next_row;
              rows_q  <= row_drive(next_row);
            end else begin
              col_idx <= lowest_col;
              state   <= DEBOUNCE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (watched_col) begin
            state   <= SCAN;
            row_idx <= next_row;
            rows_q  <= row_drive(next_row);
            dwell   <= '0;
            deb     <= '0;
          end else if (deb == DEB_LAST) begin
            key_code_q  <= {row_idx, col_idx};
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state       <= HELD;
            deb         <= '0;
          end else begin
            deb <= deb + 1'b1;
          end
        end

        HELD: begin
          if (watched_col) begin
            state <= RELEASE;
            deb   <= '0;
          end
        end

        RELEASE: begin
          if (!watched_col) begin
            state <= HELD;
            deb   <= '0;
          end else if (deb == DEB_LAST) begin
            state      <= SCAN;
            key_held_q <= 1'b0;
            row_idx    <= next_row;
            rows_q     <= row_drive(next_row);
            dwell      <= '0;
            deb        <= '0;
          end else begin
            deb <= deb + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
          dwell <= '0;
          deb   <= '0;
        end
      endcase
    end
  end

  // Registered outputs are presented straight onto the interface.
  assign kp.rows      = rows_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
